// File: rtl/resp_frame_decoder_if.sv
// Receive-side bundle between the demodulator/controller and resp_frame_decoder.
// prog and ftype carry the program and type fields; both original names are SV keywords.
interface resp_frame_decoder_if;
    logic       swiptAlive;
    logic [1:0] prog;
    logic       readDataIn;
    logic       din;
    logic [1:0] mode;
    logic [1:0] ftype;
    logic       dataInReady;
    logic [7:0] dataIn;
    logic       checkSumBit;
    logic       frameError;

    modport master (
        output swiptAlive, prog, readDataIn, din, mode, ftype,
        input  dataInReady, dataIn, checkSumBit, frameError
    );

    modport slave (
        input  swiptAlive, prog, readDataIn, din, mode, ftype,
        output dataInReady, dataIn, checkSumBit, frameError
    );
endinterface

// File: rtl/resp_frame_decoder.sv
// SWIPT response-channel receive decoder: preamble hunt, differential pair decode, parity and trailer check.
// Define RESP_HEADER_CHECK_EN to reject frames whose decoded header differs from {mode, ftype}.
module resp_frame_decoder #(
    parameter int BIT_CYCLES = 200000
) (
    input  logic                clk,
    input  logic                nrst,
    resp_frame_decoder_if.slave bus
);
    // states: HUNT preamble search | HEADER mode/type pairs | PAYLOAD data pairs | PARITY pair | TRAILER 0101
    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_HEADER  = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_TRAILER = 3'd4;

    localparam logic [5:0] PREAMBLE = 6'b101010;
    localparam logic [3:0] TRAILER  = 4'b0101;

    localparam int            PW       = $clog2(BIT_CYCLES);
    localparam logic [PW-1:0] PH_FIRST = PW'(BIT_CYCLES / 2 - 1);
    localparam logic [PW-1:0] PH_NEXT  = PW'(BIT_CYCLES - 1);

    logic          en;
    logic          ds_meta;
    logic          ds;
    logic          ds_q;
    logic          edge_det;
    logic          samp;
    logic          first;
    logic [PW-1:0] ph;

    logic [2:0]    state;
    logic [5:0]    hunt_sr;
    logic [5:0]    hunt_next;
    logic [2:0]    cnt;
    logic          have_a;
    logic          a_bit;
    logic [7:0]    data;
    logic          par_ok;
    logic [2:0]    trl;
`ifdef RESP_HEADER_CHECK_EN
    logic [2:0]    hdr;
`endif

    assign en        = bus.swiptAlive & (bus.prog == 2'b11) & bus.readDataIn;
    assign edge_det  = ds ^ ds_q;
    assign samp      = en & (ph == (first ? PH_FIRST : PH_NEXT));
    assign hunt_next = {hunt_sr[4:0], ds};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ds_meta <= 1'b0;
            ds      <= 1'b0;
            ds_q    <= 1'b0;
        end else begin
            ds_meta <= bus.din;
            ds      <= ds_meta;
            ds_q    <= ds;
        end
    end

    // Phase counter: an edge re-centres sampling half a bit later; otherwise one sample per bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ph    <= '0;
            first <= 1'b1;
        end else if (!en || edge_det) begin
            ph    <= '0;
            first <= 1'b1;
        end else if (samp) begin
            ph    <= '0;
            first <= 1'b0;
        end else if (ph != PH_NEXT) begin
            ph    <= ph + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= ST_HUNT;
            hunt_sr         <= '0;
            cnt             <= '0;
            have_a          <= 1'b0;
            a_bit           <= 1'b0;
            data            <= '0;
            par_ok          <= 1'b0;
            trl             <= '0;
`ifdef RESP_HEADER_CHECK_EN
            hdr             <= '0;
`endif
            bus.dataInReady <= 1'b0;
            bus.frameError  <= 1'b0;
            bus.dataIn      <= '0;
            bus.checkSumBit <= 1'b0;
        end else begin
            bus.dataInReady <= 1'b0;
            bus.frameError  <= 1'b0;
            if (!en) begin
                state   <= ST_HUNT;
                hunt_sr <= '0;
                cnt     <= '0;
                have_a  <= 1'b0;
                a_bit   <= 1'b0;
                data    <= '0;
                par_ok  <= 1'b0;
                trl     <= '0;
`ifdef RESP_HEADER_CHECK_EN
                hdr     <= '0;
`endif
            end else if (samp) begin
                case (state)
                    ST_HUNT: begin
                        hunt_sr <= hunt_next;
                        if (hunt_next == PREAMBLE) begin
                            state  <= ST_HEADER;
                            cnt    <= '0;
                            have_a <= 1'b0;
                            data   <= '0;
                        end
                    end
                    ST_HEADER, ST_PAYLOAD, ST_PARITY: begin
                        if (!have_a) begin
                            have_a <= 1'b1;
                            a_bit  <= ds;
                        end else if (a_bit == ds) begin
                            have_a         <= 1'b0;
                            bus.frameError <= 1'b1;
                            state          <= ST_HUNT;
                            hunt_sr        <= '0;
                            cnt            <= '0;
                        end else begin
                            have_a <= 1'b0;
                            case (state)
                                ST_HEADER: begin
`ifdef RESP_HEADER_CHECK_EN
                                    hdr <= {hdr[1:0], ds};
`endif
                                    if (cnt == 3'd3) begin
                                        cnt <= '0;
`ifdef RESP_HEADER_CHECK_EN
                                        if ({hdr, ds} != {bus.mode, bus.ftype}) begin
                                            bus.frameError <= 1'b1;
                                            state          <= ST_HUNT;
                                            hunt_sr        <= '0;
                                        end else begin
                                            state <= ST_PAYLOAD;
                                        end
`else
                                        state <= ST_PAYLOAD;
`endif
                                    end else begin
                                        cnt <= cnt + 3'd1;
                                    end
                                end
                                ST_PAYLOAD: begin
                                    data <= {data[6:0], ds};
                                    if (cnt == 3'd7) begin
                                        state <= ST_PARITY;
                                        cnt   <= '0;
                                    end else begin
                                        cnt <= cnt + 3'd1;
                                    end
                                end
                                default: begin
                                    par_ok <= (ds == ^data);
                                    state  <= ST_TRAILER;
                                    cnt    <= '0;
                                    trl    <= '0;
                                end
                            endcase
                        end
                    end
                    ST_TRAILER: begin
                        trl <= {trl[1:0], ds};
                        if (cnt == 3'd3) begin
                            state   <= ST_HUNT;
                            hunt_sr <= '0;
                            cnt     <= '0;
                            if ({trl, ds} == TRAILER) begin
                                bus.dataIn      <= data;
                                bus.checkSumBit <= par_ok;
                                bus.dataInReady <= 1'b1;
                            end else begin
                                bus.frameError  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    default: begin
                        state   <= ST_HUNT;
                        hunt_sr <= '0;
                        cnt     <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/resp_frame_decoder.md
# resp_frame_decoder

Bit-level receive decoder for the SWIPT response channel. It sits between the demodulator (`ReadData`, which drives the serial `din` level) and the transaction controller (`Data`). It hunts the 36-bit response frame, decodes the differential bit pairs and checks parity and trailer. It then hands one data byte to the controller with a single-cycle ready strobe. The frame format mirrors the transmit frame: preamble `101010`, mode pairs, type pairs, 8 data pairs, parity pair, trailer `0101`, sent MSB first.

## Interface
Parameters:
- `BIT_CYCLES`, default 200000: clock cycles per frame bit (2 ms at 100 MHz). Must be even and ≥ 8.

Ports:
- `clk`  in  1: system clock.
- `nrst`  in  1: reset, asynchronous, active-low.
- `swiptAlive`  in  1: link alive. When low, the decoder is held idle.
- `program`  in  2: active program. The decoder runs only when this is `2'b11`.
- `readDataIn`  in  1: receive window enable from the controller.
- `din`  in  1: demodulated serial level (asynchronous to `clk`).
- `mode`  in  2: expected mode field.
- `type`  in  2: expected type field.
- `dataInReady`  out  1: one-cycle strobe when a frame completes.
- `dataIn`  out  8: decoded data byte.
- `checkSumBit`  out  1: 1 when the received parity matches the data.
- `frameError`  out  1: one-cycle strobe on an aborted frame.

## Operation
- **Enable gate:** `en = swiptAlive & (program == 2'b11) & readDataIn`.
  - `en` low → state HUNT; shift registers and bit counter cleared; strobes 0.
  - `dataIn` and `checkSumBit` hold their values.
- **Input synchronizer:** `din` passes through a 2-flop synchronizer (`ds`).
- **Bit clock recovery:**
  - Any edge on `ds` reloads the phase counter to 0.
  - The first sample is taken when the counter reaches `BIT_CYCLES/2 - 1`.
  - Later samples are taken every `BIT_CYCLES` cycles while no edge occurs.
  - The counter saturates between samples and never wraps.
- **HUNT:** each sample shifts into a 6-bit register, MSB first. A match with `6'b101010` → HEADER, and the pair counter is cleared.
- **Pair decoding:** in HEADER, PAYLOAD and PARITY, samples are taken in pairs (a, b).
  - The pair is valid iff a ≠ b; the decoded bit is b.
  - An invalid pair → `frameError` strobe, then HUNT.
- **HEADER:** 4 pairs → `{mode[1], mode[0], type[1], type[0]}` received. Then → PAYLOAD.
- **PAYLOAD:** 8 pairs, MSB first, shifted into a data register. Then → PARITY.
- **PARITY:** 1 pair. The received bit is compared with `^data`; the result is latched as `par_ok`. Then → TRAILER.
- **TRAILER:** 4 single samples, which must equal `0101`.
  - Match → `dataIn <= data`, `checkSumBit <= par_ok`, `dataInReady` high for one cycle, then HUNT.
  - Mismatch → `frameError` strobe, then HUNT. `dataIn` is unchanged.
- **Parity failure:** still delivers the byte with `checkSumBit = 0`. The controller decides what to do with it.

## Timing
- **Reset values:**
  - `dataInReady` = 0, `dataIn` = 8'h00, `checkSumBit` = 0, `frameError` = 0.
  - State HUNT; all counters and shift registers 0.
- **Latency:** a `din` edge is visible internally 2 cycles later. `dataInReady` asserts on the clock edge following the 4th trailer sample.
- **Strobes:** each strobe is exactly 1 cycle wide. `dataInReady` and `frameError` are never high together.
- **Simultaneous events:**
  - `en` falling in the same cycle as frame completion → no strobe and no output update; the gate wins.
  - An edge in the same cycle as a scheduled sample → the sample is taken and the counter is reloaded.
- **Reset mid-frame:** `nrst` low clears everything asynchronously. No strobe is emitted.
- **Back-to-back frames:** HUNT resumes immediately after completion. The preamble of the next frame may start on the next bit.

## Configuration
- `RESP_HEADER_CHECK_EN`:
  - **Defined:** a decoded header that differs from `{mode, type}` → `frameError` strobe at the end of HEADER, then HUNT.
  - **Undefined:** header pairs are still checked for validity (a ≠ b), but their values are ignored. Any mode/type is accepted.

## Test plan
Run with `BIT_CYCLES = 8`.
- **Clean frame:** data `8'hA5`, parity bit 0, correct header, `RESP_HEADER_CHECK_EN` defined → one `dataInReady` pulse, `dataIn = 8'hA5`, `checkSumBit = 1`, `frameError` never high.
- **Wrong parity:** same frame with the parity pair inverted → `dataInReady` pulse, `dataIn = 8'hA5`, `checkSumBit = 0`.
- **Invalid pair:** pair `11` in payload bit 3 → `frameError` pulse after that pair, no `dataInReady`, `dataIn` unchanged. A following valid frame with `8'h3C` → `dataIn = 8'h3C`.
- **Header mismatch:** header `{2'b01, 2'b10}` vs expected `{2'b11, 2'b00}`:
  - Macro defined → `frameError` pulse.
  - Macro undefined → `dataInReady` pulse with the correct byte.
- **Gate drop:** `readDataIn` dropped during payload bit 5, then restored → no strobes. A full frame `8'hFF` sent afterwards → `dataIn = 8'hFF`. Noise `1010` before a preamble must not cause a false lock.
- **Async reset mid-trailer:** assert `nrst` low during the trailer → all outputs 0 immediately, no strobe after release.
